// File: rtl/spram_bist_pkg.sv
// Shared definitions for the single-port RAM March C- BIST.
// Contents: march element enum (M0..M5), RAM op enum, FSM state enum,
// and a per-element descriptor table (address direction, op count, op list).
package spram_bist_pkg;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;

  // R0/W0 use the background pattern, R1/W1 use its complement.
  typedef enum logic [1:0] {OP_R0, OP_R1, OP_W0, OP_W1} march_op_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} bist_state_e;

  typedef struct packed {
    logic      down;   // 1 = walk addresses D-1..0
    logic [1:0] nops;  // ops per address (1 or 2)
    march_op_e op0;
    march_op_e op1;    // ignored when nops == 1
  } elem_desc_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
  function automatic elem_desc_t elem_desc(input march_elem_e e);
    elem_desc_t d;
    case (e)
      M0:      d = '{down: 1'b0, nops: 2'd1, op0: OP_W0, op1: OP_W0};
      M1:      d = '{down: 1'b0, nops: 2'd2, op0: OP_R0, op1: OP_W1};
      M2:      d = '{down: 1'b0, nops: 2'd2, op0: OP_R1, op1: OP_W0};
      M3:      d = '{down: 1'b1, nops: 2'd2, op0: OP_R0, op1: OP_W1};
      M4:      d = '{down: 1'b1, nops: 2'd2, op0: OP_R1, op1: OP_W0};
      default: d = '{down: 1'b0, nops: 2'd1, op0: OP_R0, op1: OP_R0};
    endcase
    return d;
  endfunction

  function automatic logic op_is_write(input march_op_e op);
    return (op == OP_W0) || (op == OP_W1);
  endfunction

  function automatic logic op_is_one(input march_op_e op);
    return (op == OP_R1) || (op == OP_W1);
  endfunction

endpackage

// File: rtl/spram_bist_checker.sv
// Read-data checker for the March BIST.
// A read issued to the RAM registers its expected value and a check flag;
// the following cycle ram_out is compared against it. Keeps a saturating
// mismatch count and captures address/data/expected of the first mismatch.
// Ports: clk, rst (sync, active-high), clear (new pass), rd_vld/rd_exp/rd_addr
// (read being executed by the RAM this cycle), ram_out, fail_addr, fail_data,
// fail_exp, err_cnt.
module spram_bist_checker #(
  parameter int data_width = 8,
  parameter int addr_width = 6,
  parameter int err_cnt_w  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_vld,
  input  logic [data_width-1:0] rd_exp,
  input  logic [addr_width-1:0] rd_addr,
  input  logic [data_width-1:0] ram_out,
  output logic [addr_width-1:0] fail_addr,
  output logic [data_width-1:0] fail_data,
  output logic [data_width-1:0] fail_exp,
  output logic [err_cnt_w-1:0]  err_cnt
);

  logic                  chk_q;
  logic [data_width-1:0] exp_q;
  logic [addr_width-1:0] addr_q;
  logic                  seen;
  logic                  mismatch;

  assign mismatch = chk_q && (ram_out != exp_q);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      chk_q     <= 1'b0;
      exp_q     <= '0;
      addr_q    <= '0;
      seen      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
      err_cnt   <= '0;
    end else begin
      chk_q  <= rd_vld;
      exp_q  <= rd_exp;
      addr_q <= rd_addr;
      if (mismatch) begin
        if (err_cnt != '1) err_cnt <= err_cnt + err_cnt_w'(1);
        if (!seen) begin
          seen      <= 1'b1;
          fail_addr <= addr_q;
          fail_data <= ram_out;
          fail_exp  <= exp_q;
        end
      end
    end
  end

endmodule

// File: rtl/spram_march_bist.sv
// March C- built-in self-test engine for a single-port RAM.
// Drives the RAM data/addr/mode inputs (all registered) one op per cycle,
// checks every read via spram_bist_checker and reports done/pass plus
// first-failure capture and a saturating mismatch count.
// Ports: clk, rst (sync, active-high), start, bg (background pattern),
// ram_data/ram_addr/ram_mode (to RAM), ram_out (from RAM), busy, done, pass,
// fail_addr, fail_data, fail_exp, err_cnt.
module spram_march_bist
  import spram_bist_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 6,
  parameter int err_cnt_w  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [data_width-1:0] bg,
  output logic [data_width-1:0] ram_data,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_mode,
  input  logic [data_width-1:0] ram_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [addr_width-1:0] fail_addr,
  output logic [data_width-1:0] fail_data,
  output logic [data_width-1:0] fail_exp,
  output logic [err_cnt_w-1:0]  err_cnt
);

  localparam logic [addr_width-1:0] ADDR_MAX = '1;

  bist_state_e           state;
  march_elem_e           elem;
  logic                  op_idx;
  logic [addr_width-1:0] addr;
  logic                  seq_end;   // last op already driven; next RUN cycle idles the RAM
  logic [data_width-1:0] bg_q;
  logic                  rd_vld;    // registered alongside ram_*: the driven op is a read

  elem_desc_t            desc;
  elem_desc_t            nxt_desc;
  march_op_e             cur_op;
  march_elem_e           nxt_elem;
  logic [2:0]            nxt_raw;
  logic                  last_op;
  logic                  last_addr;
  logic                  clear;

  always_comb begin
    desc      = elem_desc(elem);
    cur_op    = op_idx ? desc.op1 : desc.op0;
    last_op   = ({1'b0, op_idx} == (desc.nops - 2'd1));
    last_addr = desc.down ? (addr == '0) : (addr == ADDR_MAX);
    nxt_raw   = elem + 3'd1;
    nxt_elem  = march_elem_e'(nxt_raw);
    nxt_desc  = elem_desc(nxt_elem);
  end

  // busy is low only in IDLE/DONE, so this is exactly an accepted start.
  assign clear = start && !busy;
  assign pass  = done && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      elem     <= M0;
      op_idx   <= 1'b0;
      addr     <= '0;
      seq_end  <= 1'b0;
      bg_q     <= '0;
      rd_vld   <= 1'b0;
      ram_data <= '0;
      ram_addr <= '0;
      ram_mode <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          ram_data <= '0;
          ram_addr <= '0;
          ram_mode <= 1'b0;
          rd_vld   <= 1'b0;
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
            bg_q    <= bg;
            elem    <= M0;
            op_idx  <= 1'b0;
            addr    <= '0;
            seq_end <= 1'b0;
          end
        end
        S_RUN: begin
          if (!seq_end) begin
            ram_mode <= op_is_write(cur_op);
            ram_addr <= addr;
            // For reads ram_data carries the expected word into the checker.
            ram_data <= op_is_one(cur_op) ? ~bg_q : bg_q;
            rd_vld   <= !op_is_write(cur_op);
            if (last_op) begin
              op_idx <= 1'b0;
              if (last_addr) begin
                if (elem == M5) begin
                  seq_end <= 1'b1;
                end else begin
                  elem <= nxt_elem;
                  addr <= nxt_desc.down ? ADDR_MAX : '0;
                end
              end else begin
                addr <= desc.down ? addr - addr_width'(1) : addr + addr_width'(1);
              end
            end else begin
              op_idx <= 1'b1;
            end
          end else begin
            ram_data <= '0;
            ram_addr <= '0;
            ram_mode <= 1'b0;
            rd_vld   <= 1'b0;
            state    <= S_DRAIN;
          end
        end
        default: begin  // S_DRAIN: final read is compared this cycle
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      endcase
    end
  end

  spram_bist_checker #(
    .data_width(data_width),
    .addr_width(addr_width),
    .err_cnt_w (err_cnt_w)
  ) u_checker (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .rd_vld   (rd_vld && !ram_mode),
    .rd_exp   (ram_data),
    .rd_addr  (ram_addr),
    .ram_out  (ram_out),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .fail_exp (fail_exp),
    .err_cnt  (err_cnt)
  );

endmodule

// File: tb/tb_spram_march_bist.sv
// Bench for spram_march_bist with D=8 behavioural RAMs carrying per-word
// stuck-at fault masks. dut1: err_cnt_w=8 (table-driven vectors, op trace);
// dut2: err_cnt_w=4 (reset mid-pass, saturation, ignored start).
module tb_spram_march_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1 = 1'b1, rst2 = 1'b1;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [7:0] bg1 = '0, bg2 = '0;
  logic [7:0] ram_data1, ram_data2, ram_out1, ram_out2;
  logic [2:0] ram_addr1, ram_addr2;
  logic       ram_mode1, ram_mode2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [2:0] fail_addr1, fail_addr2;
  logic [7:0] fail_data1, fail_data2, fail_exp1, fail_exp2;
  logic [7:0] err_cnt1;
  logic [3:0] err_cnt2;

  spram_march_bist #(.data_width(8), .addr_width(3), .err_cnt_w(8)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .bg(bg1),
    .ram_data(ram_data1), .ram_addr(ram_addr1), .ram_mode(ram_mode1), .ram_out(ram_out1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fail_addr1), .fail_data(fail_data1), .fail_exp(fail_exp1), .err_cnt(err_cnt1));

  spram_march_bist #(.data_width(8), .addr_width(3), .err_cnt_w(4)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .bg(bg2),
    .ram_data(ram_data2), .ram_addr(ram_addr2), .ram_mode(ram_mode2), .ram_out(ram_out2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2), .fail_data(fail_data2), .fail_exp(fail_exp2), .err_cnt(err_cnt2));

  // Behavioural single-port RAMs: registered read, write leaves out unchanged.
  // Masked bits read back as the fault value (stuck-at).
  logic [7:0] mem1[8], mask1[8], val1[8];
  logic [7:0] mem2[8], mask2[8], val2[8];
  initial begin ram_out1 = '0; ram_out2 = '0; end

  always @(posedge clk) begin
    if (ram_mode1) mem1[ram_addr1] <= ram_data1;
    else ram_out1 <= (mem1[ram_addr1] & ~mask1[ram_addr1]) | (val1[ram_addr1] & mask1[ram_addr1]);
    if (ram_mode2) mem2[ram_addr2] <= ram_data2;
    else ram_out2 <= (mem2[ram_addr2] & ~mask2[ram_addr2]) | (val2[ram_addr2] & mask2[ram_addr2]);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected RAM-side ops for the trace run.
  typedef struct { logic mode; logic [2:0] addr; logic [7:0] data; } op_t;
  op_t sb[$];

  function automatic void push_op(input logic m, input int a, input logic [7:0] d);
    op_t o;
    o.mode = m; o.addr = a[2:0]; o.data = d;
    sb.push_back(o);
  endfunction

  function automatic void push_march(input logic [7:0] b);
    for (int i = 0; i < 8; i++) push_op(1'b1, i, b);                                   // M0 up w0
    for (int i = 0; i < 8; i++) begin push_op(1'b0, i, b);   push_op(1'b1, i, ~b); end // M1 up r0,w1
    for (int i = 0; i < 8; i++) begin push_op(1'b0, i, ~b);  push_op(1'b1, i, b);  end // M2 up r1,w0
    for (int i = 7; i >= 0; i--) begin push_op(1'b0, i, b);  push_op(1'b1, i, ~b); end // M3 down r0,w1
    for (int i = 7; i >= 0; i--) begin push_op(1'b0, i, ~b); push_op(1'b1, i, b);  end // M4 down r1,w0
    for (int i = 0; i < 8; i++) push_op(1'b0, i, b);                                   // M5 up r0
  endfunction

  // Pulses start on the chosen DUT and waits (bounded) for done. lat = number of
  // edges after the start-sampling edge until done is seen, -1 on timeout.
  task automatic run_pass(input bit d2, input bit trace, input int mid_start,
                          output int lat, output bit busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    if (d2) start2 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    if ((d2 ? busy2 : busy1) !== 1'b1) busy_ok = 1'b0;
    if (trace) begin sb.delete(); push_march(bg1); end
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      if (n == mid_start) begin if (d2) start2 = 1'b1; else start1 = 1'b1; end
      @(posedge clk); #1;
      start1 = 1'b0; start2 = 1'b0;
      if ((d2 ? done2 : done1) === 1'b1) lat = n;
      else if ((d2 ? busy2 : busy1) !== 1'b1) busy_ok = 1'b0;
      if (trace && n <= 80) begin
        if (sb.size() == 0) chk("trace_underflow", 1, 0);
        else begin
          op_t o = sb.pop_front();
          chk($sformatf("trace_mode[%0d]", n-1), ram_mode1, o.mode);
          chk($sformatf("trace_addr[%0d]", n-1), ram_addr1, o.addr);
          if (o.mode) chk($sformatf("trace_wdata[%0d]", n-1), ram_data1, o.data);
        end
      end
      if (trace && n == 81) chk("trace_idle_after_80", ram_mode1, 0);
    end
  endtask

  typedef struct {
    logic [7:0] bg;
    int         fa;      // faulty word, -1 = none
    logic [7:0] fmask;
    logic [7:0] fval;
    bit         trace;
    bit         exp_pass;
    logic [7:0] exp_err;
    logic [2:0] exp_faddr;
    logic [7:0] exp_fdata;
    logic [7:0] exp_fexp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  lat;
    bit  bok;

    vecs[0] = '{8'h00, -1, 8'h00, 8'h00, 0, 1, 8'd0, 3'd0, 8'h00, 8'h00};
    vecs[1] = '{8'h00,  5, 8'h01, 8'h01, 0, 0, 8'd3, 3'd5, 8'h01, 8'h00}; // bit0 SA1
    vecs[2] = '{8'hA5, -1, 8'h00, 8'h00, 1, 1, 8'd0, 3'd0, 8'h00, 8'h00}; // trace
    vecs[3] = '{8'hFF,  0, 8'h80, 8'h80, 0, 0, 8'd2, 3'd0, 8'h80, 8'h00}; // r1 reads fail
    vecs[4] = '{8'h00,  2, 8'h08, 8'h00, 0, 0, 8'd2, 3'd2, 8'hF7, 8'hFF}; // bit3 SA0
    vecs[5] = '{8'h3C,  7, 8'h02, 8'h02, 0, 0, 8'd3, 3'd7, 8'h3E, 8'h3C};

    for (int a = 0; a < 8; a++) begin
      mask1[a] = '0; val1[a] = '0; mask2[a] = '0; val2[a] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",      busy1, 0);
    chk("rst_done",      done1, 0);
    chk("rst_pass",      pass1, 0);
    chk("rst_ram_mode",  ram_mode1, 0);
    chk("rst_ram_addr",  ram_addr1, 0);
    chk("rst_ram_data",  ram_data1, 0);
    chk("rst_err_cnt",   err_cnt1, 0);
    chk("rst_fail_addr", fail_addr1, 0);
    chk("rst_fail_data", fail_data1, 0);
    chk("rst_fail_exp",  fail_exp1, 0);
    rst1 = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < 8; a++) begin mask1[a] = '0; val1[a] = '0; end
      if (vecs[v].fa >= 0) begin
        mask1[vecs[v].fa] = vecs[v].fmask;
        val1[vecs[v].fa]  = vecs[v].fval;
      end
      bg1 = vecs[v].bg;
      run_pass(1'b0, vecs[v].trace, 0, lat, bok);
      chk($sformatf("v%0d_done_latency", v), lat, 82);
      chk($sformatf("v%0d_busy_whole_pass", v), bok, 1);
      chk($sformatf("v%0d_pass", v), pass1, vecs[v].exp_pass);
      chk($sformatf("v%0d_err_cnt", v), err_cnt1, vecs[v].exp_err);
      if (!vecs[v].exp_pass) begin
        chk($sformatf("v%0d_fail_addr", v), fail_addr1, vecs[v].exp_faddr);
        chk($sformatf("v%0d_fail_data", v), fail_data1, vecs[v].exp_fdata);
        chk($sformatf("v%0d_fail_exp", v),  fail_exp1,  vecs[v].exp_fexp);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_sticky", v), done1, 1);
      chk($sformatf("v%0d_idle_mode", v), ram_mode1, 0);
    end

    // Reset in the middle of a failing pass aborts it immediately.
    for (int a = 0; a < 8; a++) begin mask2[a] = 8'hFF; val2[a] = 8'hFF; end
    bg2 = 8'h00;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    chk("pre_rst_err_nonzero", (err_cnt2 != 0), 1);
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    chk("midrst_busy",     busy2, 0);
    chk("midrst_done",     done2, 0);
    chk("midrst_ram_mode", ram_mode2, 0);
    chk("midrst_err_cnt",  err_cnt2, 0);
    @(posedge clk); #1;
    chk("midrst_stays_idle", busy2, 0);

    for (int a = 0; a < 8; a++) begin mask2[a] = '0; val2[a] = '0; end
    run_pass(1'b1, 1'b0, 0, lat, bok);
    chk("after_rst_latency", lat, 82);
    chk("after_rst_busy",    bok, 1);
    chk("after_rst_pass",    pass2, 1);
    chk("after_rst_err",     err_cnt2, 0);

    // All words stuck at FF: 24 mismatches saturate a 4-bit counter; a start
    // pulse in mid-pass must not restart or stretch the pass.
    for (int a = 0; a < 8; a++) begin mask2[a] = 8'hFF; val2[a] = 8'hFF; end
    run_pass(1'b1, 1'b0, 30, lat, bok);
    chk("sat_latency",   lat, 82);
    chk("sat_busy",      bok, 1);
    chk("sat_err_cnt",   err_cnt2, 4'hF);
    chk("sat_pass",      pass2, 0);
    chk("sat_fail_addr", fail_addr2, 0);
    chk("sat_fail_data", fail_data2, 8'hFF);
    chk("sat_fail_exp",  fail_exp2, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
